rtc_read_sequencer: RTL and testbench

Bus master that reads one frame of 11 time/date/timer registers from the external RTC over its multiplexed 8-bit address/data bus. Each returned byte is presented with an index and a one-cycle valid strobe. It sits directly upstream of the display register bank, which latches the bytes by index and multiplexes them to the VGA text stage. One frame per start pulse; it never auto-repeats.

---
 rtl/rtc_read_sequencer.sv | 153 +++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_read_sequencer.sv
// Reads one 11-register time/date frame from the RTC over its multiplexed A/D bus,
// presenting each byte with its index and a one-cycle valid strobe.
module rtc_read_sequencer #(
    parameter int unsigned T_PH   = 10,
    parameter int unsigned N_REGS = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] adbus_in,
    output logic [7:0] adbus_out,
    output logic       adbus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] data_out,
    output logic [3:0] data_index,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned     PH_W     = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(T_PH - 1);
    localparam logic [3:0]      IDX_LAST = 4'(N_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_HOLD,
        S_TURN,
        S_DATA,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic [PH_W-1:0] r_ph;
    logic [3:0]      r_idx;
    logic            w_ph_last;
    logic [3:0]      w_idx_next;

    assign w_ph_last  = (r_ph == PH_LAST);
    assign w_idx_next = r_idx + 4'd1;

    // RTC register address for each frame index
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_addr = 8'h21;
            4'd1:    reg_addr = 8'h22;
            4'd2:    reg_addr = 8'h23;
            4'd3:    reg_addr = 8'h24;
            4'd4:    reg_addr = 8'h25;
            4'd5:    reg_addr = 8'h26;
            4'd6:    reg_addr = 8'h27;
            4'd7:    reg_addr = 8'h28;
            4'd8:    reg_addr = 8'h41;
            4'd9:    reg_addr = 8'h42;
            4'd10:   reg_addr = 8'h43;
            default: reg_addr = 8'h00;
        endcase
    endfunction

    // Outputs are set on the edge that enters each state, so they line up with the state itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ph       <= '0;
            r_idx      <= 4'd0;
            adbus_out  <= 8'h00;
            adbus_oe   <= 1'b0;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            ad_n       <= 1'b1;
            data_out   <= 8'h00;
            data_index <= 4'd0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_ph <= w_ph_last ? '0 : r_ph + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ADDR;
                        r_idx     <= 4'd0;
                        busy      <= 1'b1;
                        cs_n      <= 1'b0;
                        ad_n      <= 1'b0;
                        wr_n      <= 1'b0;
                        adbus_oe  <= 1'b1;
                        adbus_out <= reg_addr(4'd0);
                    end
                end
                S_ADDR: begin
                    if (w_ph_last) begin
                        r_state <= S_ADDR_HOLD;
                        wr_n    <= 1'b1;
                    end
                end
                S_ADDR_HOLD: begin
                    if (w_ph_last) begin
                        r_state  <= S_TURN;
                        cs_n     <= 1'b1;
                        ad_n     <= 1'b1;
                        adbus_oe <= 1'b0;
                    end
                end
                S_TURN: begin
                    if (w_ph_last) begin
                        r_state <= S_DATA;
                        cs_n    <= 1'b0;
                        rd_n    <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_ph_last) begin
                        r_state    <= S_RELEASE;
                        cs_n       <= 1'b1;
                        rd_n       <= 1'b1;
                        data_out   <= adbus_in;
                        data_index <= r_idx;
                        data_valid <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (w_ph_last) begin
                        if (r_idx < IDX_LAST) begin
                            r_state   <= S_ADDR;
                            r_idx     <= w_idx_next;
                            cs_n      <= 1'b0;
                            ad_n      <= 1'b0;
                            wr_n      <= 1'b0;
                            adbus_oe  <= 1'b1;
                            adbus_out <= reg_addr(w_idx_next);
                        end else begin
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: table-driven frame vectors, scoreboard of expected
// bytes, bus protocol monitors, mid-frame reset, and a T_PH=1 back-to-back instance.
module tb_rtc_read_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // DUT with default timing
    logic       reset, start;
    logic [7:0] ad_in, ad_out, dout;
    logic       oe, cs_n, rd_n, wr_n, ad_n, dv, busy, fd;
    logic [3:0] didx;

    // DUT with single-cycle phases
    logic       rst1, start1;
    logic [7:0] ad_in1, ad_out1, dout1;
    logic       oe1, cs1_n, rd1_n, wr1_n, ad1_n, dv1, busy1, fd1;
    logic [3:0] didx1;

    rtc_read_sequencer #(.T_PH(10), .N_REGS(11)) dut (
        .clk(clk), .reset(reset), .start(start), .adbus_in(ad_in),
        .adbus_out(ad_out), .adbus_oe(oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_n(ad_n), .data_out(dout), .data_index(didx), .data_valid(dv),
        .busy(busy), .frame_done(fd)
    );

    rtc_read_sequencer #(.T_PH(1), .N_REGS(11)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .adbus_in(ad_in1),
        .adbus_out(ad_out1), .adbus_oe(oe1), .cs_n(cs1_n), .rd_n(rd1_n), .wr_n(wr1_n),
        .ad_n(ad1_n), .data_out(dout1), .data_index(didx1), .data_valid(dv1),
        .busy(busy1), .frame_done(fd1)
    );

    function automatic logic [7:0] tb_addr(input int i);
        case (i)
            0: tb_addr = 8'h21;  1: tb_addr = 8'h22;  2: tb_addr = 8'h23;
            3: tb_addr = 8'h24;  4: tb_addr = 8'h25;  5: tb_addr = 8'h26;
            6: tb_addr = 8'h27;  7: tb_addr = 8'h28;  8: tb_addr = 8'h41;
            9: tb_addr = 8'h42; 10: tb_addr = 8'h43;
            default: tb_addr = 8'h00;
        endcase
    endfunction

    // RTC model: returns 0x50 + table position of the latched address
    function automatic logic [7:0] rtc_val(input logic [7:0] a);
        rtc_val = 8'hEE;
        for (int i = 0; i < 11; i++) begin
            if (tb_addr(i) == a) rtc_val = 8'(8'h50 + i);
        end
    endfunction

    logic [7:0] lat0 = 8'h00, lat1 = 8'h00;
    always @(posedge clk) if (!cs_n && !ad_n && !wr_n) lat0 <= ad_out;
    always @(posedge clk) if (!cs1_n && !ad1_n && !wr1_n) lat1 <= ad_out1;
    assign ad_in  = !rd_n  ? rtc_val(lat0) : 8'hFF;
    assign ad_in1 = !rd1_n ? rtc_val(lat1) : 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected read bytes and frame completions
    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [3:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   fd_q[$];
    int   busy_until = 0;

    task automatic push_frame(input int c);
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            e.cyc  = c + 41 + 50 * i;
            e.data = 8'(8'h50 + i);
            e.idx  = 4'(i);
            sb_q.push_back(e);
        end
        fd_q.push_back(c + 551);
    endtask

    task automatic drive_start(input logic st);
        start = st;
        if (st && cyc >= busy_until) begin
            push_frame(cyc);
            busy_until = cyc + 551;
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    exp_t       got;
    int         fd_exp;
    int         oe_run = 0;
    logic       oe_stable = 1'b1;
    logic [7:0] oe_first = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            oe_run    = 0;
            oe_stable = 1'b1;
        end else begin
            if (!rd_n) begin
                chk("rd_vs_oe", oe, 0);
                chk("rd_vs_wr", wr_n, 1);
            end
            if (oe) begin
                if (oe_run == 0) oe_first = ad_out;
                else if (ad_out !== oe_first) oe_stable = 1'b0;
                oe_run++;
            end else if (oe_run != 0) begin
                chk("addr_visible_cycles", oe_run, 20);
                chk("addr_stable", oe_stable, 1);
                oe_run    = 0;
                oe_stable = 1'b1;
            end
            if (dv) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: data 0x%0h index %0d at cycle %0d", dout, didx, cyc);
                end else begin
                    got = sb_q.pop_front();
                    chk("valid_cycle", cyc, got.cyc);
                    chk("valid_data", dout, got.data);
                    chk("valid_index", didx, got.idx);
                end
            end
            if (fd) begin
                if (fd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame_done: at cycle %0d", cyc);
                end else begin
                    fd_exp = fd_q.pop_front();
                    chk("frame_done_cycle", cyc, fd_exp);
                end
            end
        end
    end

    // Back-to-back frame monitor for the T_PH=1 instance
    int f1_valids = 0, f1_frames = 0, f1_addr0 = -1, f1_done = -1;
    always @(negedge clk) begin
        if (!rst1) begin
            if (!rd1_n) begin
                chk("t1_rd_vs_oe", oe1, 0);
                chk("t1_rd_vs_wr", wr1_n, 1);
            end
            if (dv1) begin
                chk("t1_data", dout1, 8'h50 + f1_valids);
                chk("t1_index", didx1, f1_valids);
                f1_valids++;
            end
            if (!wr1_n && ad_out1 == 8'h21) begin
                if (f1_done >= 0) chk("t1_done_to_addr", cyc - f1_done, 1);
                f1_addr0 = cyc;
            end
            if (fd1) begin
                chk("t1_frame_len", cyc - f1_addr0, 55);
                chk("t1_valid_count", f1_valids, 11);
                f1_valids = 0;
                f1_frames++;
                f1_done = cyc;
            end
        end
    end

    // Frame vectors: cycle offset from the start cycle, start to drive, expected outputs
    typedef struct {
        int         off;
        logic       st;
        logic [5:0] ctl;    // {cs_n, rd_n, wr_n, ad_n, oe, busy}
        logic       chk_a;
        logic [7:0] aout;
        logic [1:0] pulses; // {data_valid, frame_done}
        logic       chk_d;
        logic [7:0] dout;
        logic [3:0] didx;
    } vec_t;

    function automatic vec_t mkv(input int off, input logic st, input logic [5:0] ctl,
                                 input logic ca, input logic [7:0] a, input logic [1:0] p,
                                 input logic cd, input logic [7:0] d, input logic [3:0] di);
        mkv.off = off; mkv.st = st; mkv.ctl = ctl; mkv.chk_a = ca; mkv.aout = a;
        mkv.pulses = p; mkv.chk_d = cd; mkv.dout = d; mkv.didx = di;
    endfunction

    vec_t vecs[$];
    int   c0, c1;

    initial begin
        vecs.push_back(mkv(  0, 1, 6'b111100, 0, 8'h00, 2'b00, 1, 8'h00, 4'd0));
        vecs.push_back(mkv(  1, 0, 6'b010011, 1, 8'h21, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 10, 0, 6'b010011, 1, 8'h21, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 11, 0, 6'b011011, 1, 8'h21, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 20, 0, 6'b011011, 1, 8'h21, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 21, 0, 6'b111101, 0, 8'h00, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 30, 0, 6'b111101, 0, 8'h00, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 31, 0, 6'b001101, 0, 8'h00, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 40, 0, 6'b001101, 0, 8'h00, 2'b00, 1, 8'h00, 4'd0));
        vecs.push_back(mkv( 41, 0, 6'b111101, 0, 8'h00, 2'b10, 1, 8'h50, 4'd0));
        vecs.push_back(mkv( 42, 0, 6'b111101, 0, 8'h00, 2'b00, 1, 8'h50, 4'd0));
        vecs.push_back(mkv( 50, 0, 6'b111101, 0, 8'h00, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv( 51, 0, 6'b010011, 1, 8'h22, 2'b00, 1, 8'h50, 4'd0));
        vecs.push_back(mkv(100, 1, 6'b111101, 0, 8'h00, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv(101, 0, 6'b010011, 1, 8'h23, 2'b00, 1, 8'h51, 4'd1));
        vecs.push_back(mkv(300, 1, 6'b111101, 0, 8'h00, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv(301, 0, 6'b010011, 1, 8'h27, 2'b00, 1, 8'h55, 4'd5));
        vecs.push_back(mkv(401, 0, 6'b010011, 1, 8'h41, 2'b00, 1, 8'h57, 4'd7));
        vecs.push_back(mkv(451, 0, 6'b010011, 1, 8'h42, 2'b00, 1, 8'h58, 4'd8));
        vecs.push_back(mkv(501, 0, 6'b010011, 1, 8'h43, 2'b00, 1, 8'h59, 4'd9));
        vecs.push_back(mkv(511, 0, 6'b011011, 1, 8'h43, 2'b00, 0, 8'h00, 4'd0));
        vecs.push_back(mkv(541, 0, 6'b111101, 0, 8'h00, 2'b10, 1, 8'h5A, 4'd10));
        vecs.push_back(mkv(550, 0, 6'b111101, 0, 8'h00, 2'b00, 1, 8'h5A, 4'd10));
        vecs.push_back(mkv(551, 0, 6'b111100, 0, 8'h00, 2'b01, 1, 8'h5A, 4'd10));
        vecs.push_back(mkv(552, 0, 6'b111100, 0, 8'h00, 2'b00, 1, 8'h5A, 4'd10));

        reset = 1'b1; rst1 = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {cs_n, rd_n, wr_n, ad_n, oe, busy}, 6'b111100);
        chk("reset_adbus_out", ad_out, 8'h00);
        chk("reset_data", {dout, didx}, 12'h000);
        chk("reset_pulses", {dv, fd}, 2'b00);
        reset = 1'b0; rst1 = 1'b0; start1 = 1'b1;

        repeat (20) begin
            @(negedge clk);
            chk("idle_ctl", {cs_n, rd_n, wr_n, ad_n, oe, busy, dv, fd}, 8'b11110000);
        end

        // Full frame, with starts at 100 and 300 that must be dropped
        @(negedge clk);
        c0 = cyc;
        foreach (vecs[i]) begin
            wait_to(c0 + vecs[i].off);
            chk($sformatf("vec%0d_ctl", i), {cs_n, rd_n, wr_n, ad_n, oe, busy}, vecs[i].ctl);
            chk($sformatf("vec%0d_pulses", i), {dv, fd}, vecs[i].pulses);
            if (vecs[i].chk_a) chk($sformatf("vec%0d_adbus_out", i), ad_out, vecs[i].aout);
            if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), {dout, didx}, {vecs[i].dout, vecs[i].didx});
            drive_start(vecs[i].st);
        end

        // Reset in the middle of a frame
        repeat (3) @(negedge clk);
        c0 = cyc;
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        wait_to(c0 + 200);
        chk("busy_before_abort", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_ctl", {cs_n, rd_n, wr_n, ad_n, oe, busy}, 6'b111100);
        chk("abort_pulses", {dv, fd}, 2'b00);
        sb_q.delete();
        fd_q.delete();
        busy_until = 0;
        wait_to(c0 + 203);
        reset = 1'b0;

        // Restart reads from index 0; a start on the frame_done cycle is accepted
        repeat (2) @(negedge clk);
        c0 = cyc;
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        chk("restart_adbus_out", ad_out, 8'h21);
        chk("restart_ctl", {wr_n, oe, busy}, 3'b011);
        wait_to(c0 + 551);
        chk("restart_frame_done", fd, 1);
        c1 = cyc;
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        chk("chained_ctl", {cs_n, wr_n, oe, busy}, 4'b0011);
        chk("chained_adbus_out", ad_out, 8'h21);
        wait_to(c1 + 560);

        chk("sb_remaining", sb_q.size(), 0);
        chk("fd_remaining", fd_q.size(), 0);
        chk("t1_enough_frames", f1_frames >= 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
